// File: rtl/branch_predictor_if.sv
// Lookup, resolve/update and statistics bundle between the MIPS pipeline and
// the branch predictor. The pipeline side uses master; the predictor uses slave.
interface branch_predictor_if;
  logic [31:0] pc;
  logic        btb_hit;
  logic        predict_taken;
  logic [31:0] pred_next_pc;

  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_pred_taken;
  logic [31:0] update_pred_target;
  logic        mispredict;
  logic [31:0] correct_pc;

  logic        flush_tbl;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output pc, update_valid, update_pc, update_taken, update_target,
           update_pred_taken, update_pred_target, flush_tbl,
    input  btb_hit, predict_taken, pred_next_pc, mispredict, correct_pc,
           branch_count, mispredict_count
  );

  modport slave (
    input  pc, update_valid, update_pc, update_taken, update_target,
           update_pred_taken, update_pred_target, flush_tbl,
    output btb_hit, predict_taken, pred_next_pc, mispredict, correct_pc,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters and mispredict stats.
// Define BRANCH_PREDICTOR_GSHARE_EN to move the counters into a GHR-indexed PHT.
module branch_predictor #(
  parameter int         ENTRIES      = 16,
  parameter logic [1:0] COUNTER_INIT = 2'b01,
  parameter int         GHR_W        = 4
) (
  input logic               CLK,
  input logic               nRST,
  branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
    logic [1:0] result;
    result = ctr;
    if (up && ctr != 2'b11) begin
      result = ctr + 2'b01;
    end else if (!up && ctr != 2'b00) begin
      result = ctr - 2'b01;
    end
    return result;
  endfunction

  logic        valid_q  [ENTRIES];
  logic        valid_d  [ENTRIES];
  tag_t        tag_q    [ENTRIES];
  tag_t        tag_d    [ENTRIES];
  logic [31:0] target_q [ENTRIES];
  logic [31:0] target_d [ENTRIES];

  logic [31:0] branch_count_q;
  logic [31:0] branch_count_d;
  logic [31:0] mispredict_count_q;
  logic [31:0] mispredict_count_d;

  idx_t l_idx;
  tag_t l_tag;
  idx_t u_idx;
  tag_t u_tag;
  logic l_hit;
  logic l_dir;
  logic predict_taken;
  logic mispredict;

  always_comb begin
    l_idx = bp.pc[IDX_W+1:2];
    l_tag = bp.pc[31:IDX_W+2];
    u_idx = bp.update_pc[IDX_W+1:2];
    u_tag = bp.update_pc[31:IDX_W+2];
    l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  end

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [1:0]       pht_q [ENTRIES];
  logic [1:0]       pht_d [ENTRIES];
  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_d;
  idx_t             ghr_ext;
  idx_t             u_pidx;
  logic             unused_bits;

  assign ghr_ext     = idx_t'(ghr_q);
  assign u_pidx      = u_idx ^ ghr_ext;
  assign l_dir       = pht_q[l_idx ^ ghr_ext][1];
  assign unused_bits = ^{bp.pc[1:0], bp.update_pc[1:0]};

  // Every resolved branch trains the PHT and shifts committed history, hit or not.
  always_comb begin
    pht_d = pht_q;
    ghr_d = ghr_q;
    if (bp.flush_tbl) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_d[i] = COUNTER_INIT;
      end
      ghr_d = '0;
    end else if (bp.update_valid) begin
      pht_d[u_pidx] = ctr_step(pht_q[u_pidx], bp.update_taken);
      ghr_d         = GHR_W'({ghr_q, bp.update_taken});
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= COUNTER_INIT;
      end
      ghr_q <= '0;
    end else begin
      pht_q <= pht_d;
      ghr_q <= ghr_d;
    end
  end
`else
  logic [1:0] ctr_q [ENTRIES];
  logic [1:0] ctr_d [ENTRIES];
  logic       u_hit;
  logic       unused_bits;

  assign u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign l_dir       = ctr_q[l_idx][1];
  assign unused_bits = ^{bp.pc[1:0], bp.update_pc[1:0], GHR_W[0]};

  // Freshly allocated entries start weakly taken, since they were just taken.
  always_comb begin
    ctr_d = ctr_q;
    if (bp.flush_tbl) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_d[i] = COUNTER_INIT;
      end
    end else if (bp.update_valid) begin
      if (u_hit) begin
        ctr_d[u_idx] = ctr_step(ctr_q[u_idx], bp.update_taken);
      end else if (bp.update_taken) begin
        ctr_d[u_idx] = 2'b10;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= COUNTER_INIT;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end
`endif

  assign predict_taken    = l_hit && l_dir;
  assign bp.btb_hit       = l_hit;
  assign bp.predict_taken = predict_taken;
  assign bp.pred_next_pc  = predict_taken ? target_q[l_idx] : bp.pc + 32'd4;

  always_comb begin
    mispredict = bp.update_valid &&
                 ((bp.update_taken != bp.update_pred_taken) ||
                  (bp.update_taken && (bp.update_target != bp.update_pred_target)));
  end

  assign bp.mispredict       = mispredict;
  assign bp.correct_pc       = bp.update_taken ? bp.update_target : bp.update_pc + 32'd4;
  assign bp.branch_count     = branch_count_q;
  assign bp.mispredict_count = mispredict_count_q;

  // A taken branch either retargets its hit entry or claims the slot; both write
  // the same fields, and a taken miss evicts any aliasing branch.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (bp.flush_tbl) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_d[i] = 1'b0;
      end
    end else if (bp.update_valid && bp.update_taken) begin
      valid_d[u_idx]  = 1'b1;
      tag_d[u_idx]    = u_tag;
      target_d[u_idx] = bp.update_target;
    end
  end

  always_comb begin
    branch_count_d     = branch_count_q + {31'd0, bp.update_valid};
    mispredict_count_d = mispredict_count_q + {31'd0, mispredict};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      valid_q            <= valid_d;
      tag_q              <= tag_d;
      target_q           <= target_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Vector table for the 16-entry, non-gshare predictor: each step's expected
// lookup, resolve and statistics outputs are queued when driven, then checked.
module tb_branch_predictor;

  typedef struct {
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        uptk;
    logic [31:0] uptgt;
    logic        fl;
    logic        e_hit;
    logic        e_tk;
    logic [31:0] e_npc;
    logic        e_mp;
    logic [31:0] e_cpc;
    logic [31:0] e_bc;
    logic [31:0] e_mc;
    int          step;
  } vec_t;

  localparam int NUM_VECS = 28;
  localparam int PART2    = 18;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   failures;
  vec_t vecs [NUM_VECS];
  vec_t exp_q [$];

  branch_predictor_if bp_if ();

  branch_predictor #(
    .ENTRIES      (16),
    .COUNTER_INIT (2'b01),
    .GHR_W        (4)
  ) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bp   (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [31:0] pc, input logic uv, input logic [31:0] upc,
    input logic ut, input logic [31:0] utgt, input logic uptk,
    input logic [31:0] uptgt, input logic fl, input logic e_hit,
    input logic e_tk, input logic [31:0] e_npc, input logic e_mp,
    input logic [31:0] e_cpc, input logic [31:0] e_bc, input logic [31:0] e_mc);
    vec_t v;
    v.pc = pc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.uptk = uptk; v.uptgt = uptgt; v.fl = fl; v.e_hit = e_hit;
    v.e_tk = e_tk; v.e_npc = e_npc; v.e_mp = e_mp; v.e_cpc = e_cpc;
    v.e_bc = e_bc; v.e_mc = e_mc; v.step = 0;
    return v;
  endfunction

  // Lookup only; update fields zero so correct_pc is 0+4.
  function automatic vec_t idle(
    input logic [31:0] pc, input logic e_hit, input logic e_tk,
    input logic [31:0] e_npc, input logic [31:0] e_bc, input logic [31:0] e_mc);
    return mk(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
              e_hit, e_tk, e_npc, 1'b0, 32'h4, e_bc, e_mc);
  endfunction

  task automatic checkVal(input string name, input int step,
                          input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s step %0d: got 0x%08h, expected 0x%08h", name, step, act, exp);
    end
  endtask

  task automatic driveIdle();
    bp_if.pc                 = 32'h0;
    bp_if.update_valid       = 1'b0;
    bp_if.update_pc          = 32'h0;
    bp_if.update_taken       = 1'b0;
    bp_if.update_target      = 32'h0;
    bp_if.update_pred_taken  = 1'b0;
    bp_if.update_pred_target = 32'h0;
    bp_if.flush_tbl          = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bp_if.pc                 = v.pc;
    bp_if.update_valid       = v.uv;
    bp_if.update_pc          = v.upc;
    bp_if.update_taken       = v.ut;
    bp_if.update_target      = v.utgt;
    bp_if.update_pred_taken  = v.uptk;
    bp_if.update_pred_target = v.uptgt;
    bp_if.flush_tbl          = v.fl;
    exp_q.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    if (exp_q.size() == 0) begin
      tests_run++;
      failures++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a pending record");
    end else begin
      e = exp_q.pop_front();
      checkVal("btb_hit",          e.step, {31'd0, bp_if.btb_hit},       {31'd0, e.e_hit});
      checkVal("predict_taken",    e.step, {31'd0, bp_if.predict_taken}, {31'd0, e.e_tk});
      checkVal("pred_next_pc",     e.step, bp_if.pred_next_pc,           e.e_npc);
      checkVal("mispredict",       e.step, {31'd0, bp_if.mispredict},    {31'd0, e.e_mp});
      checkVal("correct_pc",       e.step, bp_if.correct_pc,             e.e_cpc);
      checkVal("branch_count",     e.step, bp_if.branch_count,           e.e_bc);
      checkVal("mispredict_count", e.step, bp_if.mispredict_count,       e.e_mc);
    end
  endtask

  // Reset lands mid-cycle while a taken update is pending; state must clear at once.
  task automatic asyncResetMidRun();
    @(negedge clk);
    bp_if.pc                 = 32'h80;
    bp_if.update_valid       = 1'b1;
    bp_if.update_pc          = 32'h80;
    bp_if.update_taken       = 1'b1;
    bp_if.update_target      = 32'h700;
    bp_if.update_pred_taken  = 1'b0;
    bp_if.update_pred_target = 32'h84;
    bp_if.flush_tbl          = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkVal("rst_btb_hit",      100, {31'd0, bp_if.btb_hit},       32'd0);
    checkVal("rst_predict",      100, {31'd0, bp_if.predict_taken}, 32'd0);
    checkVal("rst_next_pc",      100, bp_if.pred_next_pc,           32'h84);
    checkVal("rst_branch_count", 100, bp_if.branch_count,           32'd0);
    checkVal("rst_misp_count",   100, bp_if.mispredict_count,       32'd0);
    checkVal("rst_mispredict",   100, {31'd0, bp_if.mispredict},    32'd1);
    checkVal("rst_correct_pc",   100, bp_if.correct_pc,             32'h700);
    @(negedge clk);
    driveIdle();
    rst_n = 1'b1;
  endtask

  initial begin
    tests_run = 0;
    failures  = 0;
    rst_n     = 1'b0;
    driveIdle();

    vecs[0]  = idle(32'h40, 0, 0, 32'h44, 0, 0);
    vecs[1]  = mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44,  0, 0, 0, 32'h44,  1, 32'h100, 0, 0);
    vecs[2]  = mk(32'h40, 1, 32'h40, 0, 32'h0,   1, 32'h100, 0, 1, 1, 32'h100, 1, 32'h44,  1, 1);
    vecs[3]  = mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44,  0, 1, 0, 32'h44,  1, 32'h100, 2, 2);
    vecs[4]  = mk(32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 0, 1, 1, 32'h100, 0, 32'h100, 3, 3);
    vecs[5]  = mk(32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 0, 1, 1, 32'h100, 0, 32'h100, 4, 3);
    vecs[6]  = mk(32'h40, 1, 32'h40, 0, 32'h0,   1, 32'h100, 0, 1, 1, 32'h100, 1, 32'h44,  5, 3);
    vecs[7]  = mk(32'h40, 1, 32'h40, 0, 32'h0,   1, 32'h100, 0, 1, 1, 32'h100, 1, 32'h44,  6, 4);
    vecs[8]  = mk(32'h40, 1, 32'h40, 0, 32'h0,   0, 32'h44,  0, 1, 0, 32'h44,  0, 32'h44,  7, 5);
    vecs[9]  = mk(32'h40, 1, 32'h40, 0, 32'h0,   0, 32'h44,  0, 1, 0, 32'h44,  0, 32'h44,  8, 5);
    vecs[10] = mk(32'h40, 0, 32'h0,  1, 32'h500, 0, 32'h0,   0, 1, 0, 32'h44,  0, 32'h500, 9, 5);
    vecs[11] = mk(32'h80, 1, 32'h80, 1, 32'h200, 0, 32'h84,  0, 0, 0, 32'h84,  1, 32'h200, 9, 5);
    vecs[12] = idle(32'h40, 0, 0, 32'h44, 10, 6);
    vecs[13] = idle(32'h80, 1, 1, 32'h200, 10, 6);
    vecs[14] = mk(32'h80, 1, 32'h80, 1, 32'h240, 1, 32'h200, 0, 1, 1, 32'h200, 1, 32'h240, 10, 6);
    vecs[15] = idle(32'h80, 1, 1, 32'h240, 11, 7);
    vecs[16] = mk(32'h10, 1, 32'h10, 0, 32'h0,   0, 32'h14,  0, 0, 0, 32'h14,  0, 32'h14,  11, 7);
    vecs[17] = idle(32'h10, 0, 0, 32'h14, 12, 7);
    vecs[18] = idle(32'h80, 0, 0, 32'h84, 0, 0);
    vecs[19] = mk(32'h10, 1, 32'h10, 0, 32'h0,   0, 32'h14,  0, 0, 0, 32'h14,  0, 32'h14,  0, 0);
    vecs[20] = idle(32'h10, 0, 0, 32'h14, 1, 0);
    vecs[21] = mk(32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 0, 0, 0, 32'h44,  0, 32'h100, 1, 0);
    vecs[22] = idle(32'h40, 1, 1, 32'h100, 2, 0);
    vecs[23] = mk(32'h40, 1, 32'hC0, 1, 32'h300, 0, 32'hC4,  1, 1, 1, 32'h100, 1, 32'h300, 2, 0);
    vecs[24] = idle(32'h40, 0, 0, 32'h44, 3, 1);
    vecs[25] = idle(32'hC0, 0, 0, 32'hC4, 3, 1);
    vecs[26] = mk(32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 3, 1);
    vecs[27] = idle(32'h40, 0, 0, 32'h44, 4, 1);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NUM_VECS; i++) begin
      if (i == PART2) begin
        asyncResetMidRun();
      end
      vecs[i].step = i;
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput();
    end

    @(negedge clk);
    driveIdle();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
